// File: rtl/fifo_uart_drain_if.sv
// FIFO read-side handshake between the dual-clock FIFO and its serial drain.
// master: the drain (pops); slave: the FIFO read port (presents head byte and empty flag).
interface fifo_uart_drain_if;
  logic       empty;
  logic [7:0] r_data;
  logic       r_inc;

  modport master (input empty, input r_data, output r_inc);
  modport slave  (output empty, output r_data, input r_inc);
endinterface

// File: rtl/fifo_uart_drain.sv
// Read-domain FIFO drain: pops one byte per frame and shifts it out LSB first as an async serial frame.
// Optional parity bit enabled by defining FIFO_UART_DRAIN_PARITY_EN (sense chosen by PARITY_ODD).
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                r_clk,
  input  logic                r_rst,
  input  logic                tx_en,
  fifo_uart_drain_if.master   rd,
  output logic                tx,
  output logic                busy
);

  localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FIFO_UART_DRAIN_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                r_inc_q, r_inc_d;
  logic                busy_q, busy_d;
  logic                bit_end;

`ifdef FIFO_UART_DRAIN_PARITY_EN
  logic                par_q, par_d;

  function automatic logic parity_of(input logic [7:0] b);
    return (^b) ^ (PARITY_ODD != 0);
  endfunction
`endif

  assign bit_end  = (baud_q == BAUD_MAX);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign rd.r_inc = r_inc_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    r_inc_d = 1'b0;
    busy_d  = busy_q;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // Always at least one IDLE cycle, so the FIFO's empty flag has caught up with the last pop.
        if (tx_en && !rd.empty) begin
          state_d = START;
          shift_d = rd.r_data;
`ifdef FIFO_UART_DRAIN_PARITY_EN
          par_d   = parity_of(rd.r_data);
`endif
          tx_d    = 1'b0;
          r_inc_d = 1'b1;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
`ifdef FIFO_UART_DRAIN_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef FIFO_UART_DRAIN_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      r_inc_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FIFO_UART_DRAIN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      r_inc_q <= r_inc_d;
      busy_q  <= busy_d;
`ifdef FIFO_UART_DRAIN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
